// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer, latch and decode blocks.
package pipeline_ctrl_pkg;

    // Sequencer state encoding, fixed so other blocks can decode it directly.
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_e;

    localparam int REG_W_DEF      = 5;
    localparam int MD_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF      = 32;

    // Width of a counter that must hold 0..limit-1.
    function automatic int cntWidth(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the DX load and the FD reader.
// Shared with the bypass logic, so keep it free of sequencer state.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    input  logic             dx_is_load,
    input  logic [REG_W-1:0] dx_rd,
    output logic             hazard
);

    logic rsMatch;
    logic rtMatch;
    logic rdLive;

    // Writes to register zero are discarded, so they never create a hazard.
    always_comb begin
        rdLive  = (dx_rd != '0);
        rsMatch = (dx_rd == fd_rs);
        rtMatch = fd_uses_rt && (dx_rd == fd_rt);
        hazard  = dx_is_load && rdLive && (rsMatch || rtMatch);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the PC/FD/DX/XM/MW latches: load-use stalls,
// taken-branch squashes and mult/div front-end freezes, plus a saturating
// stall-cycle counter for performance debug.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int REG_W      = REG_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    input  logic             dx_is_load,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_is_multdiv,
    input  logic             dx_branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TO_W = cntWidth(MD_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    ctrl_state_e     state;
    ctrl_state_e     stateNext;
    logic [TO_W-1:0] toCnt;
    logic [TO_W-1:0] toCntNext;
    logic            hazard;
    logic            forcedRelease;
    logic            mdTimeoutReg;
    logic [CNT_W-1:0] stallCnt;

    // Raw (pre-reset-gating) controls from the next-state logic.
    logic pcEnRaw;
    logic fdEnRaw;
    logic dxEnRaw;
    logic xmEnRaw;
    logic mwEnRaw;
    logic fdFlushRaw;
    logic dxFlushRaw;
    logic xmFlushRaw;
    logic mdStartRaw;
    logic mdBusyRaw;

    load_use_detect #(
        .REG_W(REG_W)
    ) uLoadUse (
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rt (fd_uses_rt),
        .dx_is_load (dx_is_load),
        .dx_rd      (dx_rd),
        .hazard     (hazard)
    );

    // State and timeout counter; reset drops straight back to RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            toCnt <= '0;
        end else begin
            state <= stateNext;
            toCnt <= toCntNext;
        end
    end

    // Next-state and latch controls; branch and load-use only matter in RUN.
    always_comb begin
        stateNext     = state;
        toCntNext     = toCnt;
        forcedRelease = 1'b0;
        pcEnRaw       = 1'b1;
        fdEnRaw       = 1'b1;
        dxEnRaw       = 1'b1;
        xmEnRaw       = 1'b1;
        mwEnRaw       = 1'b1;
        fdFlushRaw    = 1'b0;
        dxFlushRaw    = 1'b0;
        xmFlushRaw    = 1'b0;
        mdStartRaw    = 1'b0;
        mdBusyRaw     = 1'b0;
        case (state)
            RUN: begin
                if (dx_is_multdiv) begin
                    // Freeze the front end, bubble into XM, kick the unit.
                    mdStartRaw = 1'b1;
                    pcEnRaw    = 1'b0;
                    fdEnRaw    = 1'b0;
                    dxEnRaw    = 1'b0;
                    xmFlushRaw = 1'b1;
                    stateNext  = MD_WAIT;
                    toCntNext  = '0;
                end else if (dx_branch_taken) begin
                    fdFlushRaw = 1'b1;
                    dxFlushRaw = 1'b1;
                end else if (hazard) begin
                    // One-cycle stall: the load moves on, a nop fills DX.
                    pcEnRaw    = 1'b0;
                    fdEnRaw    = 1'b0;
                    dxFlushRaw = 1'b1;
                end
            end
            MD_WAIT: begin
                mdBusyRaw = 1'b1;
                if (md_ready || (toCnt == TO_LAST)) begin
                    // Release: the op advances to XM with everything enabled.
                    stateNext     = RUN;
                    forcedRelease = !md_ready;
                end else begin
                    pcEnRaw    = 1'b0;
                    fdEnRaw    = 1'b0;
                    dxEnRaw    = 1'b0;
                    xmFlushRaw = 1'b1;
                    toCntNext  = toCnt + 1'b1;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // Sticky flag recording that a mult/div was released without md_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mdTimeoutReg <= 1'b0;
        end else if (forcedRelease) begin
            mdTimeoutReg <= 1'b1;
        end
    end

    // Saturating count of cycles where the PC was held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (!pc_en && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    // While reset is asserted every latch control is held inactive.
    assign pc_en        = reset & pcEnRaw;
    assign fd_en        = reset & fdEnRaw;
    assign dx_en        = reset & dxEnRaw;
    assign xm_en        = reset & xmEnRaw;
    assign mw_en        = reset & mwEnRaw;
    assign fd_flush     = reset & fdFlushRaw;
    assign dx_flush     = reset & dxFlushRaw;
    assign xm_flush     = reset & xmFlushRaw;
    assign md_start     = reset & mdStartRaw;
    assign md_busy      = mdBusyRaw;
    assign md_timeout   = mdTimeoutReg;
    assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Instance A uses default parameters;
// instance B uses a short timeout and a 4-bit counter to reach the timeout
// and saturation corners quickly. Both share the same input stimulus.
module tb_pipeline_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic       fd_uses_rt;
    logic       dx_is_load;
    logic [4:0] dx_rd;
    logic       dx_is_multdiv;
    logic       dx_branch_taken;
    logic       md_ready;

    logic        pcEnA, fdEnA, dxEnA, xmEnA, mwEnA;
    logic        fdFlA, dxFlA, xmFlA, mdStartA, mdBusyA, mdToA;
    logic [31:0] stallA;
    logic        pcEnB, fdEnB, dxEnB, xmEnB, mwEnB;
    logic        fdFlB, dxFlB, xmFlB, mdStartB, mdBusyB, mdToB;
    logic [3:0]  stallB;

    int nChecks = 0;
    int nErrors = 0;
    int startsA = 0;

    pipeline_ctrl dutA (
        .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .dx_is_multdiv(dx_is_multdiv), .dx_branch_taken(dx_branch_taken),
        .md_ready(md_ready), .pc_en(pcEnA), .fd_en(fdEnA), .dx_en(dxEnA),
        .xm_en(xmEnA), .mw_en(mwEnA), .fd_flush(fdFlA), .dx_flush(dxFlA),
        .xm_flush(xmFlA), .md_start(mdStartA), .md_busy(mdBusyA),
        .md_timeout(mdToA), .stall_cycles(stallA)
    );

    pipeline_ctrl #(.MD_TIMEOUT(8), .CNT_W(4), .REG_W(5)) dutB (
        .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .dx_is_multdiv(dx_is_multdiv), .dx_branch_taken(dx_branch_taken),
        .md_ready(md_ready), .pc_en(pcEnB), .fd_en(fdEnB), .dx_en(dxEnB),
        .xm_en(xmEnB), .mw_en(mwEnB), .fd_flush(fdFlB), .dx_flush(dxFlB),
        .xm_flush(xmFlB), .md_start(mdStartB), .md_busy(mdBusyB),
        .md_timeout(mdToB), .stall_cycles(stallB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Enables packed {pc,fd,dx,xm,mw}; flushes packed {fd,dx,xm}.
    wire [4:0] enA = {pcEnA, fdEnA, dxEnA, xmEnA, mwEnA};
    wire [2:0] flA = {fdFlA, dxFlA, xmFlA};
    wire [4:0] enB = {pcEnB, fdEnB, dxEnB, xmEnB, mwEnB};
    wire [2:0] flB = {fdFlB, dxFlB, xmFlB};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clrIn();
        fd_rs = '0; fd_rt = '0; fd_uses_rt = 1'b0; dx_is_load = 1'b0;
        dx_rd = '0; dx_is_multdiv = 1'b0; dx_branch_taken = 1'b0; md_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clrIn();
        repeat (2) tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // Reset then idle; a pending mult/div must not start while in reset.
        reset = 1'b0;
        clrIn();
        dx_is_multdiv = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_en", 32'(enA), 32'h00);
            chk("rst_start", 32'(mdStartA), 32'h0);
        end
        chk("rst_stall", stallA, 32'd0);
        dx_is_multdiv = 1'b0;
        reset = 1'b1;
        #1;
        chk("idle_en", 32'(enA), 32'h1f);
        chk("idle_fl", 32'(flA), 32'h0);
        chk("idle_busy", 32'(mdBusyA), 32'h0);
        tick();
        chk("idle_stall", stallA, 32'd0);

        // Load-use on rs.
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5;
        #1;
        chk("lu_en", 32'(enA), 32'h07);
        chk("lu_fl", 32'(flA), 32'h2);
        tick();
        clrIn();
        #1;
        chk("lu_stall", stallA, 32'd1);
        chk("lu_after_en", 32'(enA), 32'h1f);

        // Load to r0 never stalls.
        dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs = 5'd0;
        #1;
        chk("lu_r0_en", 32'(enA), 32'h1f);
        tick();
        // rt match ignored when rt is not read, honoured when it is.
        dx_rd = 5'd5; fd_rs = 5'd3; fd_rt = 5'd5; fd_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(enA), 32'h1f);
        fd_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(enA), 32'h07);
        tick();
        clrIn();
        #1;
        chk("lu_stall2", stallA, 32'd2);

        // Branch taken wins over a simultaneous load-use.
        dx_branch_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5;
        #1;
        chk("br_en", 32'(enA), 32'h1f);
        chk("br_fl", 32'(flA), 32'h6);
        tick();
        clrIn();
        #1;
        chk("br_stall", stallA, 32'd2);

        // Mult/div: 10 wait cycles, then md_ready.
        doReset();
        dx_is_multdiv = 1'b1;
        #1;
        chk("md_start", 32'(mdStartA), 32'h1);
        chk("md_start_en", 32'(enA), 32'h03);
        chk("md_start_fl", 32'(flA), 32'h1);
        startsA = startsA + int'(mdStartA);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("md_wait_busy", 32'(mdBusyA), 32'h1);
            chk("md_wait_en", 32'(enA), 32'h03);
            chk("md_wait_fl", 32'(flA), 32'h1);
            startsA = startsA + int'(mdStartA);
            tick();
        end
        md_ready = 1'b1;
        #1;
        chk("md_rel_busy", 32'(mdBusyA), 32'h1);
        chk("md_rel_en", 32'(enA), 32'h1f);
        chk("md_rel_fl", 32'(flA), 32'h0);
        startsA = startsA + int'(mdStartA);
        tick();
        clrIn();
        #1;
        chk("md_starts", 32'(startsA), 32'd1);
        chk("md_stall", stallA, 32'd11);
        chk("md_to", 32'(mdToA), 32'h0);
        chk("md_idle_busy", 32'(mdBusyA), 32'h0);

        // Back-to-back mult/div ops.
        doReset();
        dx_is_multdiv = 1'b1;
        #1;
        chk("b2b_start1", 32'(mdStartA), 32'h1);
        tick();
        md_ready = 1'b1;
        #1;
        chk("b2b_rel1_start", 32'(mdStartA), 32'h0);
        chk("b2b_rel1_en", 32'(enA), 32'h1f);
        tick();
        md_ready = 1'b0;
        #1;
        chk("b2b_start2", 32'(mdStartA), 32'h1);
        tick();
        md_ready = 1'b1;
        #1;
        chk("b2b_rel2_start", 32'(mdStartA), 32'h0);
        tick();
        clrIn();
        #1;
        chk("b2b_idle_busy", 32'(mdBusyA), 32'h0);
        chk("b2b_stall", stallA, 32'd2);

        // Timeout on instance B (MD_TIMEOUT=8): 7 held cycles + release.
        doReset();
        dx_is_multdiv = 1'b1;
        #1;
        chk("to_start", 32'(mdStartB), 32'h1);
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("to_wait_en", 32'(enB), 32'h03);
            chk("to_wait_busy", 32'(mdBusyB), 32'h1);
            tick();
        end
        chk("to_rel_en", 32'(enB), 32'h1f);
        chk("to_rel_fl", 32'(flB), 32'h0);
        chk("to_rel_flag", 32'(mdToB), 32'h0);
        tick();
        clrIn();
        #1;
        chk("to_flag", 32'(mdToB), 32'h1);
        chk("to_busy", 32'(mdBusyB), 32'h0);
        chk("to_stall", 32'(stallB), 32'd8);
        repeat (5) tick();
        chk("to_sticky", 32'(mdToB), 32'h1);

        // Saturation on B's 4-bit counter: 8 + 10 stalls clamps at 15.
        dx_is_load = 1'b1; dx_rd = 5'd7; fd_rs = 5'd7;
        repeat (10) tick();
        chk("sat_hold", 32'(stallB), 32'hf);
        repeat (2) tick();
        chk("sat_hold2", 32'(stallB), 32'hf);
        chk("sat_sticky", 32'(mdToB), 32'h1);
        clrIn();

        // Reset asserted mid-MD_WAIT.
        dx_is_multdiv = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_busy_pre", 32'(mdBusyA), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(mdBusyA), 32'h0);
        chk("mid_en", 32'(enA), 32'h00);
        chk("mid_start", 32'(mdStartA), 32'h0);
        chk("mid_stall", stallA, 32'd0);
        chk("mid_toB", 32'(mdToB), 32'h0);
        chk("mid_stallB", 32'(stallB), 32'h0);
        dx_is_multdiv = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_start", 32'(mdStartA), 32'h0);
        chk("mid_rel_en", 32'(enA), 32'h1f);
        tick();
        chk("mid_rel_stall", stallA, 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches: PC, FD, DX, XM and MW.
- Generates the per-latch enables and the bubble (flush) controls.
- Resolves three conditions:
  - load-use hazards, by stalling one cycle;
  - taken branches, by squashing two instructions;
  - multi-cycle mult/div ops, by freezing the front end until the multdiv unit reports ready or times out.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_TIMEOUT, 64, maximum cycles spent in MD_WAIT before a forced release (must be ≥2).
- CNT_W, 32, width of the stall_cycles counter.
- REG_W, 5, register-specifier width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- fd_rs  in  REG_W  rs field of the instruction in FD.
- fd_rt  in  REG_W  rt field of the instruction in FD.
- fd_uses_rt  in  1  the FD instruction reads rt.
- dx_is_load  in  1  the DX instruction is lw.
- dx_rd  in  REG_W  destination register of the DX instruction.
- dx_is_multdiv  in  1  the DX instruction is mul or div.
- dx_branch_taken  in  1  a branch or jump in DX resolved taken.
- md_ready  in  1  the multdiv result is valid this cycle.
- pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  latch write enables.
- fd_flush  out  1  FD loads a nop.
- dx_flush  out  1  DX loads a nop.
- xm_flush  out  1  XM loads a nop.
- md_start  out  1  one-cycle start pulse to the multdiv unit.
- md_busy  out  1  high while in MD_WAIT.
- md_timeout  out  1  sticky flag: a forced release occurred.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, timeout counter=0, md_timeout=0, stall_cycles=0.
  - While reset is low, all enables, flushes and md_start are forced to 0.
- States: RUN, MD_WAIT.
- Outputs are combinational from state and inputs. Default: all enables 1, all flushes 0, md_start 0.
- RUN, conditions evaluated in priority order:
  1. dx_is_multdiv:
     - md_start=1; pc_en=fd_en=dx_en=0; xm_flush=1 (XM receives a bubble); mw_en=1.
     - Next state MD_WAIT; timeout counter cleared to 0.
  2. dx_branch_taken:
     - fd_flush=1, dx_flush=1, all enables 1.
     - Remain in RUN.
  3. Load-use hazard:
     - Condition: dx_is_load && dx_rd!=0 && (dx_rd==fd_rs || (fd_uses_rt && dx_rd==fd_rt)).
     - Outputs: pc_en=fd_en=0, dx_flush=1, dx_en=xm_en=mw_en=1.
     - The stall lasts exactly one cycle, because the load leaves DX.
  4. Otherwise: defaults.
- MD_WAIT:
  - md_busy=1.
  - If md_ready, or the timeout counter equals MD_TIMEOUT-1:
    - All enables 1, no flushes; the mult/div instruction advances to XM.
    - Next state RUN.
    - If md_ready=0 (forced release), set md_timeout=1.
  - Otherwise: pc_en=fd_en=dx_en=0, xm_flush=1, mw_en=1, timeout counter +1.
  - md_start is never asserted in MD_WAIT.
  - dx_branch_taken and load-use hazards are ignored in MD_WAIT.
- Back-to-back mult/div:
  - The release cycle moves the first op out of DX.
  - The next cycle in RUN sees the second op and issues a new md_start.
  - There is never a double start for the same instruction.
- md_ready in RUN is ignored.
- stall_cycles:
  - Increments on every clock edge where pc_en=0 and reset=1.
  - Saturates at all-ones and never wraps.
  - The MD_WAIT release cycle is not counted (pc_en=1 there).
- md_timeout clears only on reset.
- Reset asserted mid-MD_WAIT returns the block to RUN immediately; no md_start is issued on release of reset unless dx_is_multdiv is set.

Decomposition:
- Shared package: state encoding constants (RUN=1'b0, MD_WAIT=1'b1) and the REG_W default, shared with the latch and decode blocks.
- Sub-module load_use_detect: purely combinational hazard compare (fd_rs, fd_rt, fd_uses_rt, dx_is_load, dx_rd → hazard). It is reused by the bypass logic later.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 3 cycles, release, all inputs 0.
  - Required: all enables 0 during reset; then all enables 1, flushes 0, stall_cycles=0.
- Load-use:
  - Stimulus: dx_is_load=1, dx_rd=5, fd_rs=5, for one cycle.
  - Required: pc_en=fd_en=0, dx_flush=1, stall_cycles=1.
  - Repeat with dx_rd=0 → no stall.
  - Repeat with fd_rt=5, fd_uses_rt=0 → no stall.
- Branch:
  - Stimulus: dx_branch_taken=1.
  - Required: fd_flush=dx_flush=1, all enables 1, stall_cycles unchanged.
- Mult/div:
  - Stimulus: dx_is_multdiv=1; md_ready rises after 10 cycles.
  - Required: md_start pulses exactly once; md_busy high for 10 cycles with front enables 0 and xm_flush=1; release cycle has all enables 1; stall_cycles=11; md_timeout=0.
- Timeout:
  - Stimulus: mult/div op with md_ready held 0, MD_TIMEOUT=8.
  - Required: forced release after 8 MD_WAIT cycles; md_timeout=1 and stays 1 until reset.
- Edge cases:
  - Back-to-back mult/div → two md_start pulses separated by the release cycle.
  - Reset pulse mid-MD_WAIT → state=RUN, md_busy=0, counters 0.
  - Preload stall_cycles near all-ones → holds at all-ones.
